// File: rtl/dc_pkg.sv
// Shared helpers for the dual-clock FIFO: constant log2, one-hot rotate,
// one-hot test and one-hot to index conversion, all on a fixed-width carrier.
package dc_pkg;

  // Widest one-hot pointer the helpers handle; BUFFER_DEPTH must stay below it.
  localparam int MAX_DEPTH = 64;

  typedef logic [MAX_DEPTH-1:0] ptr_wide_t;

  // Ceiling log2 written as a bounded loop so it elaborates on any tool.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic ptr_wide_t rotl1(input ptr_wide_t v, input int depth);
    ptr_wide_t r;
    r = '0;
    for (int i = 0; i < MAX_DEPTH - 1; i++) begin
      if (i < depth - 1) r[6'(i + 1)] = v[6'(i)];
    end
    r[0] = v[6'(depth - 1)];
    return r;
  endfunction

  function automatic logic is_onehot(input ptr_wide_t v);
    return (v != '0) && ((v & (v - ptr_wide_t'(1))) == '0);
  endfunction

  function automatic int oh_to_idx(input ptr_wide_t v);
    int r;
    r = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (v[6'(i)]) r = r | i;
    end
    return r;
  endfunction

endpackage

// File: rtl/dc_pointer_sync.sv
// Multi-stage synchroniser for a pointer crossing into this clock domain.
// Every stage resets to RESET_VAL so the chain starts out agreeing with the pointers.
module dc_pointer_sync #(
  parameter int               WIDTH     = 8,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= RESET_VAL;
    end else begin
      stage_q[0] <= async_in;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign sync_out = stage_q[STAGES-1];

endmodule

// File: rtl/dc_fifo_write_ctrl.sv
// Write-side controller of the dual-clock FIFO: one-hot write pointer, data
// pass-through to the buffer, and full detection against the synced read pointer.
module dc_fifo_write_ctrl
  import dc_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  input  logic [BUFFER_DEPTH-1:0]   read_pointer,
  output logic [BUFFER_DEPTH-1:0]   write_pointer,
  output logic [DATA_WIDTH-1:0]     write_data,
  output logic [log2(BUFFER_DEPTH):0] fill_level
);

  localparam int FILL_W = log2(BUFFER_DEPTH) + 1;
  localparam logic [BUFFER_DEPTH-1:0] PTR_RESET = {{(BUFFER_DEPTH-1){1'b0}}, 1'b1};

  // Handshake: a word transfers on a rising clk edge where valid_in && ready_out.
  // ready_out comes only from registers; the upstream holds data_in stable while
  // valid_in is high and ready_out is low.
  logic [BUFFER_DEPTH-1:0] wp_q, wp_d;
  logic [BUFFER_DEPTH-1:0] rp_hold_q, rp_hold_d;
  logic [BUFFER_DEPTH-1:0] rp_sync, wp_next;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic                    active_q;
  logic                    full, accept;
  ptr_wide_t               wp_rot_wide;
  logic                    unused_rot_hi;
  int                      wr_idx, rd_idx, diff;

  dc_pointer_sync #(
    .WIDTH    (BUFFER_DEPTH),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(PTR_RESET)
  ) u_rp_sync (
    .clk     (clk),
    .rstn    (rstn),
    .async_in(read_pointer),
    .sync_out(rp_sync)
  );

  assign wp_rot_wide   = rotl1(ptr_wide_t'(wp_q), BUFFER_DEPTH);
  assign wp_next       = wp_rot_wide[BUFFER_DEPTH-1:0];
  assign unused_rot_hi = ^wp_rot_wide[MAX_DEPTH-1:BUFFER_DEPTH];

  // One slot is sacrificed so that full and empty stay distinguishable.
  assign full      = (wp_next == rp_hold_q);
  assign ready_out = active_q && !full;
  assign accept    = valid_in && ready_out;

  always_comb begin
    wp_d      = wp_q;
    rp_hold_d = rp_hold_q;
    if (accept) wp_d = wp_next;
    // Mid-transition samples of the read pointer are not one-hot; keep the last good one.
    if (is_onehot(ptr_wide_t'(rp_sync))) rp_hold_d = rp_sync;
    wr_idx = oh_to_idx(ptr_wide_t'(wp_q));
    rd_idx = oh_to_idx(ptr_wide_t'(rp_hold_q));
    diff   = (wr_idx >= rd_idx) ? (wr_idx - rd_idx) : (wr_idx + BUFFER_DEPTH - rd_idx);
    fill_d = FILL_W'(diff);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q      <= PTR_RESET;
      rp_hold_q <= PTR_RESET;
      fill_q    <= '0;
      active_q  <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_hold_q <= rp_hold_d;
      fill_q    <= fill_d;
      active_q  <= 1'b1;
    end
  end

  assign write_pointer = wp_q;
  assign write_data    = data_in;
  assign fill_level    = fill_q;

endmodule

// File: tb/tb_dc_fifo_write_ctrl.sv
// Bench for dc_fifo_write_ctrl: directed vector table for fill/wrap/glitch/
// simultaneous cases, reset sequences, and a random stream against a drained buffer model.
module tb_dc_fifo_write_ctrl;

  logic        clk;
  logic        rclk;
  logic        rstn;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  read_pointer;
  logic [7:0]  write_pointer;
  logic [31:0] write_data;
  logic [3:0]  fill_level;

  logic [7:0]  rp_tb;
  logic [7:0]  rp_rd;
  logic        stream_on;

  int n_vec;
  int n_err;

  logic [31:0] exp_q[$];
  logic [31:0] mem [8];
  bit          slot_full [8];

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic [7:0]  rp;
    logic [7:0]  exp_wp;
    logic        exp_ready;
    logic [3:0]  exp_fill;
  } vec_t;

  vec_t vecs [23];

  assign read_pointer = stream_on ? rp_rd : rp_tb;

  dc_fifo_write_ctrl #(
    .DATA_WIDTH  (32),
    .BUFFER_DEPTH(8),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .read_pointer (read_pointer),
    .write_pointer(write_pointer),
    .write_data   (write_data),
    .fill_level   (fill_level)
  );

  // clk posedges at 5 mod 10; rclk posedges land on 0,2,4,6,8 mod 10, never on a clk posedge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rclk = 1'b0;
    #1;
    forever #7 rclk = ~rclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [7:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic vec_t mk(input logic valid, input logic [31:0] data, input logic [7:0] rp,
                              input logic [7:0] exp_wp, input logic exp_ready, input logic [3:0] exp_fill);
    vec_t v;
    v.valid     = valid;
    v.data      = data;
    v.rp        = rp;
    v.exp_wp    = exp_wp;
    v.exp_ready = exp_ready;
    v.exp_fill  = exp_fill;
    return v;
  endfunction

  // Read side for the stream phase: drains one word every third rclk edge.
  initial begin
    int rd_cnt;
    int slot;
    rd_cnt = 0;
    forever begin
      @(posedge rclk);
      if (stream_on) begin
        rd_cnt++;
        if ((rd_cnt % 3) == 0 && rp_rd != write_pointer) begin
          slot = oh_idx(rp_rd);
          chk("slot_written", 32'(slot_full[slot]), 32'd1);
          if (exp_q.size() == 0) chk("queue_nonempty", 32'd0, 32'd1);
          else chk("stream_order", mem[slot], exp_q.pop_front());
          slot_full[slot] = 1'b0;
          rp_rd = {rp_rd[6:0], rp_rd[7]};
        end
      end
    end
  end

  initial begin
    bit pending;
    int slot;
    n_vec     = 0;
    n_err     = 0;
    stream_on = 1'b0;
    rp_tb     = 8'h01;
    rp_rd     = 8'h01;
    rstn      = 1'b0;
    valid_in  = 1'b1;
    data_in   = 32'hdead_beef;
    for (int i = 0; i < 8; i++) slot_full[i] = 1'b0;

    // fill: 7 accepts then full
    vecs[0]  = mk(1, 0, 8'h01, 8'h02, 1, 0);
    vecs[1]  = mk(1, 1, 8'h01, 8'h04, 1, 1);
    vecs[2]  = mk(1, 2, 8'h01, 8'h08, 1, 2);
    vecs[3]  = mk(1, 3, 8'h01, 8'h10, 1, 3);
    vecs[4]  = mk(1, 4, 8'h01, 8'h20, 1, 4);
    vecs[5]  = mk(1, 5, 8'h01, 8'h40, 1, 5);
    vecs[6]  = mk(1, 6, 8'h01, 8'h80, 0, 6);
    vecs[7]  = mk(1, 7, 8'h01, 8'h80, 0, 7);
    vecs[8]  = mk(1, 7, 8'h01, 8'h80, 0, 7);
    vecs[9]  = mk(1, 7, 8'h01, 8'h80, 0, 7);
    // wrap: read pointer advances, ready returns after the sync chain plus rp_hold
    vecs[10] = mk(1, 7, 8'h02, 8'h80, 0, 7);
    vecs[11] = mk(1, 7, 8'h02, 8'h80, 0, 7);
    vecs[12] = mk(1, 7, 8'h02, 8'h80, 1, 7);
    vecs[13] = mk(1, 7, 8'h04, 8'h01, 0, 6);
    // simultaneous: rp_hold advances on the edge of vector 15, accept only on vector 16
    vecs[14] = mk(1, 8, 8'h04, 8'h01, 0, 7);
    vecs[15] = mk(1, 8, 8'h04, 8'h01, 1, 7);
    vecs[16] = mk(1, 8, 8'h04, 8'h02, 0, 6);
    vecs[17] = mk(0, 0, 8'h04, 8'h02, 0, 7);
    // glitch: zero-hot then two-hot samples must be ignored
    vecs[18] = mk(0, 0, 8'h00, 8'h02, 0, 7);
    vecs[19] = mk(0, 0, 8'h06, 8'h02, 0, 7);
    vecs[20] = mk(0, 0, 8'h04, 8'h02, 0, 7);
    vecs[21] = mk(0, 0, 8'h04, 8'h02, 0, 7);
    vecs[22] = mk(0, 0, 8'h04, 8'h02, 0, 7);

    // reset from power-up with valid asserted
    #23;
    chk("rst_ready", 32'(ready_out), 32'd0);
    chk("rst_wp", 32'(write_pointer), 32'h01);
    chk("rst_fill", 32'(fill_level), 32'd0);
    @(negedge clk);
    rstn     = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready_out), 32'd1);
    chk("post_rst_wp", 32'(write_pointer), 32'h01);
    chk("post_rst_fill", 32'(fill_level), 32'd0);

    for (int k = 0; k < 23; k++) begin
      valid_in = vecs[k].valid;
      data_in  = vecs[k].data;
      rp_tb    = vecs[k].rp;
      #1;
      chk($sformatf("v%0d_write_data", k), write_data, vecs[k].data);
      @(negedge clk);
      chk($sformatf("v%0d_wp", k), 32'(write_pointer), 32'(vecs[k].exp_wp));
      chk($sformatf("v%0d_ready", k), 32'(ready_out), 32'(vecs[k].exp_ready));
      chk($sformatf("v%0d_fill", k), 32'(fill_level), 32'(vecs[k].exp_fill));
    end

    // reset mid-operation, asserted between clock edges
    #2;
    rstn     = 1'b0;
    valid_in = 1'b1;
    rp_tb    = 8'h01;
    #1;
    chk("mid_rst_wp", 32'(write_pointer), 32'h01);
    chk("mid_rst_ready", 32'(ready_out), 32'd0);
    chk("mid_rst_fill", 32'(fill_level), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold_wp", 32'(write_pointer), 32'h01);
    chk("mid_rst_hold_ready", 32'(ready_out), 32'd0);
    @(negedge clk);
    rstn     = 1'b1;
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rel_ready", 32'(ready_out), 32'd1);
    chk("mid_rel_wp", 32'(write_pointer), 32'h01);
    chk("mid_rel_fill", 32'(fill_level), 32'd0);

    // random stream against a read side draining at a third of rclk
    rp_rd     = 8'h01;
    stream_on = 1'b1;
    pending   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      chk("stream_fill_le7", 32'(fill_level <= 4'd7), 32'd1);
      if (!pending) begin
        valid_in = 1'($urandom_range(0, 1));
        data_in  = $urandom;
      end
      #1;
      if (valid_in && ready_out) begin
        slot = oh_idx(write_pointer);
        chk("no_overwrite", 32'(slot_full[slot]), 32'd0);
        mem[slot]       = data_in;
        slot_full[slot] = 1'b1;
        exp_q.push_back(data_in);
        pending = 1'b0;
      end else begin
        pending = valid_in;
      end
      @(negedge clk);
    end
    valid_in = 1'b0;
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (6) @(negedge clk);
    chk("drain_fill", 32'(fill_level), 32'd0);
    chk("drain_ready", 32'(ready_out), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
